mastermind_round_ctrl: RTL
==========================

MASTERMIND_ROUND_CTRL -- requirements
Module: mastermind_round_ctrl

Interface
REQ-001 The block SHALL have one parameter: MAX_GUESSES, default 8, the number of scored guesses allowed per game (legal range 1..15).
REQ-002 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 Port reset, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 Port load, input, 1 bit: active-high level of the player's load button.
REQ-005 Port red, input, 3 bits: registered red-peg count from the compare engine.
REQ-006 Port code_we, output, 1 bit: one-cycle write strobe for a secret-code digit.
REQ-007 Port guess_we, output, 1 bit: one-cycle write strobe for a guess digit.
REQ-008 Port digit_sel, output, 2 bits: index (0..3) of the digit being written, or the compare index while scoring.
REQ-009 Port clear_score, output, 1 bit: one-cycle clear of the compare engine's red/white/matched state.
REQ-010 Port compare_en, output, 1 bit: compare-step enable to the compare engine.
REQ-011 Port guess_count, output, 4 bits: number of guesses scored in the current game.
REQ-012 Port phase, output, 2 bits: 0 CODE, 1 GUESS, 2 SCORE, 3 DONE.
REQ-013 Ports win and lose, outputs, 1 bit each: game result flags.

Function
REQ-014 A press SHALL be defined as load==1 while load_q==0, where load_q is load registered on every clock edge.
REQ-015 States SHALL be CODE, GUESS, CLEAR, SCORE, EVAL and DONE, plus a 2-bit digit counter dcnt; phase SHALL report CLEAR, SCORE and EVAL as 2.
REQ-016 CODE: a press SHALL assert code_we combinationally in the same cycle with digit_sel=dcnt, then increment dcnt.
- On the press with dcnt==3: dcnt wraps to 0 and the state becomes GUESS.
REQ-017 GUESS: a press SHALL assert guess_we combinationally with digit_sel=dcnt, then increment dcnt.
- On the press with dcnt==3: dcnt wraps to 0 and the state becomes CLEAR.
REQ-018 CLEAR SHALL last exactly one cycle, with clear_score=1 and all other strobes 0; next state SCORE.
REQ-019 SCORE SHALL last exactly four cycles, with compare_en=1 and digit_sel=0,1,2,3 in successive cycles; next state EVAL.
REQ-020 EVAL SHALL last one cycle, with compare_en=0, and SHALL increment guess_count.
- If red==4: set win=1 and go to DONE (win takes priority over the guess limit).
- Else, if the incremented guess_count equals MAX_GUESSES: set lose=1 and go to DONE.
- Else: go to GUESS with dcnt=0.
REQ-021 Presses during CLEAR, SCORE and EVAL SHALL be ignored, with no strobe and no state effect; a button still held from the 4th guess digit SHALL NOT produce a press on return to GUESS.
REQ-022 DONE: win/lose SHALL hold and no strobes SHALL be issued.
- A press SHALL clear win, lose, guess_count and dcnt, go to CODE, and SHALL NOT write a digit in that cycle.
REQ-023 code_we, guess_we, clear_score and compare_en SHALL be mutually exclusive in every cycle.
REQ-024 Outside CODE/GUESS press cycles and SCORE, digit_sel SHALL be 0.
REQ-025 guess_count SHALL never exceed MAX_GUESSES and SHALL never wrap.

Reset
REQ-026 While reset==1 at a clock edge, the next state SHALL be: state CODE, dcnt=0, guess_count=0, win=0, lose=0, load_q=1.
REQ-027 Because load_q resets to 1, a button held through reset release SHALL NOT count as a press until it is released and pressed again.
REQ-028 Reset asserted mid-operation (including during SCORE) SHALL abort immediately, with no further compare_en or write strobes after the reset edge.
REQ-029 During and after reset, all strobes SHALL be 0 and phase SHALL be 0.

Verification
REQ-030 Code entry: after reset, 4 press/release pairs give code_we pulses with digit_sel 0,1,2,3 (one cycle each); phase then becomes 1.
REQ-031 Scoring sequence: the 4th guess press gives clear_score for 1 cycle, then compare_en for 4 cycles (digit_sel 0..3), then EVAL; guess_count goes 0->1.
REQ-032 Win: red driven to 4 in EVAL gives win=1 and phase=3; subsequent presses issue no strobes until one press returns the block to phase 0 with win=0 and guess_count=0.
REQ-033 Lose: with MAX_GUESSES=8 and red held at 2, the 8th EVAL gives lose=1 and guess_count=8; no 9th guess is accepted.
REQ-034 Held button and mid-score reset:
- load held across the 4th guess digit and the whole SCORE sequence gives no extra guess_we.
- reset pulsed in the 2nd SCORE cycle gives compare_en=0 from the next cycle and phase=0.
- load held through reset release gives no code_we until it is released and pressed again.

Source files
------------

// File: rtl/mastermind_round_ctrl.sv
// Round controller for a Mastermind game: sequences code entry, guess entry,
// the four-step compare engine scoring pass and the win/lose decision.
module mastermind_round_ctrl #(
  parameter int unsigned MAX_GUESSES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [2:0] red,
  output logic       code_we,
  output logic       guess_we,
  output logic [1:0] digit_sel,
  output logic       clear_score,
  output logic       compare_en,
  output logic [3:0] guess_count,
  output logic [1:0] phase,
  output logic       win,
  output logic       lose
);

  typedef enum logic [2:0] {
    S_CODE,
    S_GUESS,
    S_CLEAR,
    S_SCORE,
    S_EVAL,
    S_DONE
  } state_t;

  localparam logic [3:0] MAX_GC = 4'(MAX_GUESSES);

  state_t     state, state_nxt;
  logic [1:0] dcnt, dcnt_nxt;
  logic [3:0] gc_nxt;
  logic       win_nxt, lose_nxt;
  logic       load_q;
  logic       press;

  // load_q tracks the button every cycle, so a button held through scoring
  // or through reset release never looks like a fresh press.
  assign press = load & ~load_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_CODE;
      dcnt        <= 2'd0;
      guess_count <= 4'd0;
      win         <= 1'b0;
      lose        <= 1'b0;
      load_q      <= 1'b1;
    end else begin
      state       <= state_nxt;
      dcnt        <= dcnt_nxt;
      guess_count <= gc_nxt;
      win         <= win_nxt;
      lose        <= lose_nxt;
      load_q      <= load;
    end
  end

  always_comb begin
    state_nxt   = state;
    dcnt_nxt    = dcnt;
    gc_nxt      = guess_count;
    win_nxt     = win;
    lose_nxt    = lose;
    code_we     = 1'b0;
    guess_we    = 1'b0;
    digit_sel   = 2'd0;
    clear_score = 1'b0;
    compare_en  = 1'b0;
    phase       = 2'd0;
    case (state)
      S_CODE: begin
        phase = 2'd0;
        if (press) begin
          code_we   = 1'b1;
          digit_sel = dcnt;
          dcnt_nxt  = dcnt + 2'd1;
          if (dcnt == 2'd3) state_nxt = S_GUESS;
        end
      end
      S_GUESS: begin
        phase = 2'd1;
        if (press) begin
          guess_we  = 1'b1;
          digit_sel = dcnt;
          dcnt_nxt  = dcnt + 2'd1;
          if (dcnt == 2'd3) state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: begin
        phase       = 2'd2;
        clear_score = 1'b1;
        state_nxt   = S_SCORE;
      end
      S_SCORE: begin
        // dcnt wrapped to 0 on the last guess digit, so it doubles as compare index.
        phase      = 2'd2;
        compare_en = 1'b1;
        digit_sel  = dcnt;
        dcnt_nxt   = dcnt + 2'd1;
        if (dcnt == 2'd3) state_nxt = S_EVAL;
      end
      S_EVAL: begin
        phase    = 2'd2;
        gc_nxt   = guess_count + 4'd1;
        dcnt_nxt = 2'd0;
        if (red == 3'd4) begin
          win_nxt   = 1'b1;
          state_nxt = S_DONE;
        end else if (gc_nxt == MAX_GC) begin
          lose_nxt  = 1'b1;
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_GUESS;
        end
      end
      S_DONE: begin
        phase = 2'd3;
        if (press) begin
          win_nxt   = 1'b0;
          lose_nxt  = 1'b0;
          gc_nxt    = 4'd0;
          dcnt_nxt  = 2'd0;
          state_nxt = S_CODE;
        end
      end
      default: state_nxt = S_CODE;
    endcase
    // Strobes are suppressed while reset is held so an abort is clean immediately.
    if (reset) begin
      code_we     = 1'b0;
      guess_we    = 1'b0;
      digit_sel   = 2'd0;
      clear_score = 1'b0;
      compare_en  = 1'b0;
      phase       = 2'd0;
    end
  end

endmodule
